// File: rtl/quant_zigzag.sv
// Quantiser after the 2-D DCT: per-position reciprocal multiply, round/saturate,
// then a ping-pong block buffer drained in JPEG zigzag order over valid/ready.
module quant_zigzag #(
   parameter int IN_W    = 15,
   parameter int OUT_W   = 12,
   parameter int RECIP_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IN_W-1:0]    in_coef,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               qt_we,
   input  logic [5:0]         qt_addr,
   input  logic [RECIP_W-1:0] qt_data,
   output logic [OUT_W-1:0]   out_data,
   output logic [5:0]         out_zz,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int PROD_W = IN_W + RECIP_W + 1;
   localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(1) <<< (RECIP_W - 1);
   localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));
   localparam logic [RECIP_W-1:0]       RECIP_DEF = RECIP_W'(4096);

   // Raster address of each zigzag position.
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic [RECIP_W-1:0]       qt_q [64];
   logic [RECIP_W-1:0]       qt_d [64];
   logic [OUT_W-1:0]         bank_mem [2][64];
   logic [5:0]               slot_q, slot_d;
   logic                     wr_sel_q, wr_sel_d;
   logic [1:0]               full_q, full_d;
   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_bank_q, s1_bank_d;
   logic [5:0]               s1_slot_q, s1_slot_d;
   logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
   logic                     rd_sel_q, rd_sel_d;
   logic [5:0]               rd_cnt_q, rd_cnt_d;
   logic [OUT_W-1:0]         out_data_q, out_data_d;
   logic [5:0]               out_zz_q, out_zz_d;
   logic                     out_last_q, out_last_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_bank_q, out_bank_d;

   logic                     accept, out_xfer, load;
   logic signed [PROD_W-1:0] coef_ext, recip_ext, rounded, shifted;
   logic [OUT_W-1:0]         q_sat;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      in_ready = ~full_q[wr_sel_q];
      accept   = in_valid & in_ready;

      qt_d = qt_q;
      if (qt_we) qt_d[qt_addr] = qt_data;

      // S1 reads the table before this cycle's write lands, so a colliding sample sees the old value.
      coef_ext   = {{(PROD_W - IN_W){in_coef[IN_W-1]}}, in_coef};
      recip_ext  = {{(PROD_W - RECIP_W){1'b0}}, qt_q[slot_q]};
      s1_prod_d  = coef_ext * recip_ext;
      s1_valid_d = accept;
      s1_bank_d  = wr_sel_q;
      s1_slot_d  = slot_q;

      slot_d   = slot_q;
      wr_sel_d = wr_sel_q;
      if (accept) begin
         slot_d = slot_q + 6'd1;
         if (slot_q == 6'd63) wr_sel_d = ~wr_sel_q;
      end

      rounded = s1_prod_q + ROUND_C;
      shifted = rounded >>> RECIP_W;
      if (shifted > SAT_MAX)      q_sat = SAT_MAX[OUT_W-1:0];
      else if (shifted < SAT_MIN) q_sat = SAT_MIN[OUT_W-1:0];
      else                        q_sat = shifted[OUT_W-1:0];

      out_xfer = out_valid_q & out_ready;
      load     = (~out_valid_q | out_ready) & full_q[rd_sel_q];

      full_d = full_q;
      if (s1_valid_q && s1_slot_q == 6'd63) full_d[s1_bank_q] = 1'b1;
      if (out_xfer && out_last_q)           full_d[out_bank_q] = 1'b0;

      // rd_sel moves on once the last entry is loaded; the bank stays full until that entry transfers.
      rd_sel_d    = rd_sel_q;
      rd_cnt_d    = rd_cnt_q;
      out_data_d  = out_data_q;
      out_zz_d    = out_zz_q;
      out_last_d  = out_last_q;
      out_bank_d  = out_bank_q;
      out_valid_d = out_valid_q & ~out_ready;
      if (load) begin
         out_data_d  = bank_mem[rd_sel_q][ZZ[rd_cnt_q]];
         out_zz_d    = rd_cnt_q;
         out_last_d  = (rd_cnt_q == 6'd63);
         out_bank_d  = rd_sel_q;
         out_valid_d = 1'b1;
         rd_cnt_d    = rd_cnt_q + 6'd1;
         if (rd_cnt_q == 6'd63) rd_sel_d = ~rd_sel_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qt_q        <= '{default: RECIP_DEF};
         slot_q      <= '0;
         wr_sel_q    <= 1'b0;
         full_q      <= '0;
         s1_valid_q  <= 1'b0;
         s1_bank_q   <= 1'b0;
         s1_slot_q   <= '0;
         s1_prod_q   <= '0;
         rd_sel_q    <= 1'b0;
         rd_cnt_q    <= '0;
         out_data_q  <= '0;
         out_zz_q    <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_bank_q  <= 1'b0;
      end else begin
         qt_q        <= qt_d;
         slot_q      <= slot_d;
         wr_sel_q    <= wr_sel_d;
         full_q      <= full_d;
         s1_valid_q  <= s1_valid_d;
         s1_bank_q   <= s1_bank_d;
         s1_slot_q   <= s1_slot_d;
         s1_prod_q   <= s1_prod_d;
         rd_sel_q    <= rd_sel_d;
         rd_cnt_q    <= rd_cnt_d;
         out_data_q  <= out_data_d;
         out_zz_q    <= out_zz_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         out_bank_q  <= out_bank_d;
      end
   end

   // NOTE: the block buffer has no reset; a bank is only read after full[] says all 64 entries were written.
   always_ff @(posedge clk) begin
      if (s1_valid_q) bank_mem[s1_bank_q][s1_slot_q] <= q_sat;
   end

   assign out_data  = out_data_q;
   assign out_zz    = out_zz_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_quant_zigzag.sv
// Directed bench for quant_zigzag: defaults, zigzag order, saturation, backpressure,
// table-write collision and reset recovery, with hand-computed expectations.
module tb_quant_zigzag;

   localparam int IN_W    = 15;
   localparam int OUT_W   = 12;
   localparam int RECIP_W = 16;

   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [IN_W-1:0]    in_coef = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               qt_we = 1'b0;
   logic [5:0]         qt_addr = '0;
   logic [RECIP_W-1:0] qt_data = '0;
   logic [OUT_W-1:0]   out_data;
   logic [5:0]         out_zz;
   logic               out_last;
   logic               out_valid;
   logic               out_ready = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int first_cyc, last_cyc;

   logic [IN_W-1:0]  stim  [64];
   logic [OUT_W-1:0] exp_r [64];
   logic [OUT_W-1:0] q_data [$];
   logic [5:0]       q_zz   [$];
   logic             q_last [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   quant_zigzag #(.IN_W(IN_W), .OUT_W(OUT_W), .RECIP_W(RECIP_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_coef(in_coef), .in_valid(in_valid), .in_ready(in_ready),
      .qt_we(qt_we), .qt_addr(qt_addr), .qt_data(qt_data),
      .out_data(out_data), .out_zz(out_zz), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // Feeds n samples from stim[]; optionally writes table entry 0 in the cycle of the first sample.
   task automatic drive(input int n, input bit qt_first, input logic [RECIP_W-1:0] qt_val);
      int i = 0;
      int guard = 0;
      logic acc;
      while (i < n && guard < 1000) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_coef  = stim[i];
         qt_we    = qt_first && (guard == 0);
         qt_addr  = 6'd0;
         qt_data  = qt_val;
         acc      = in_ready;
         @(posedge clk);
         if (acc) i++;
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      qt_we    = 1'b0;
      tests_run++;
      if (i != n) begin
         tests_failed++;
         $display("FAIL drive_accepts: got %0d accepted, expected %0d", i, n);
      end
   endtask

   // Called at a negedge; records transfers until n are seen or the cycle budget runs out.
   task automatic collect(input int n, input int max_cyc);
      int c = 0;
      q_data.delete(); q_zz.delete(); q_last.delete();
      out_ready = 1'b1;
      while (q_data.size() < n && c < max_cyc) begin
         if (out_valid) begin
            q_data.push_back(out_data);
            q_zz.push_back(out_zz);
            q_last.push_back(out_last);
            if (q_data.size() == 1) first_cyc = cyc;
            last_cyc = cyc;
         end
         @(negedge clk);
         c++;
      end
      out_ready = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; qt_we = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      tests_run++;
      if ({out_valid, out_data, out_zz, out_last} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid %b data %0d zz %0d last %b, expected all 0",
                  out_valid, out_data, out_zz, out_last);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL release_state: got in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_default_quant();
      for (int i = 0; i < 64; i++) begin stim[i] = '0; exp_r[i] = '0; end
      stim[0] = 15'd1000;   exp_r[0] = 12'd63;
      stim[1] = -15'sd1000; exp_r[1] = -12'sd62;
      drive(64, 1'b0, '0);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL latency_1: got out_valid %b expected 0", out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL latency_2: got out_valid %b expected 0", out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 12'd63 || out_zz !== 6'd0) begin
         tests_failed++;
         $display("FAIL latency_3: got valid %b data %0d zz %0d, expected 1 63 0", out_valid, $signed(out_data), out_zz);
      end
      collect(64, 200);
      tests_run++;
      if (q_data.size() != 64) begin
         tests_failed++; $display("FAIL default_count: got %0d outputs expected 64", q_data.size());
      end
      for (int k = 0; k < q_data.size(); k++) begin
         tests_run++;
         if (q_data[k] !== exp_r[ZZ[k]] || q_zz[k] !== 6'(k) || q_last[k] !== (k == 63)) begin
            tests_failed++;
            $display("FAIL default_out[%0d]: got data %0d zz %0d last %b, expected %0d %0d %b",
                     k, $signed(q_data[k]), q_zz[k], q_last[k], $signed(exp_r[ZZ[k]]), k, (k == 63));
         end
      end
   endtask

   task automatic test_zigzag_order();
      for (int i = 0; i < 64; i++) begin
         qt_we = 1'b1; qt_addr = 6'(i); qt_data = 16'hFFFF;
         @(negedge clk);
      end
      qt_we = 1'b0;
      for (int i = 0; i < 64; i++) begin stim[i] = 15'(i); exp_r[i] = 12'(i); end
      drive(64, 1'b0, '0);
      collect(64, 200);
      tests_run++;
      if (q_data.size() != 64) begin
         tests_failed++; $display("FAIL zigzag_count: got %0d outputs expected 64", q_data.size());
      end
      for (int k = 0; k < q_data.size(); k++) begin
         tests_run++;
         if (q_data[k] !== exp_r[ZZ[k]] || q_zz[k] !== 6'(k) || q_last[k] !== (k == 63)) begin
            tests_failed++;
            $display("FAIL zigzag_out[%0d]: got data %0d zz %0d last %b, expected %0d %0d %b",
                     k, $signed(q_data[k]), q_zz[k], q_last[k], $signed(exp_r[ZZ[k]]), k, (k == 63));
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 64; i++) begin stim[i] = '0; exp_r[i] = '0; end
      stim[0] = 15'h3FFF; exp_r[0] = 12'h7FF;
      stim[1] = 15'h4000; exp_r[1] = 12'h800;
      stim[2] = 15'd100;  exp_r[2] = 12'd100;
      drive(64, 1'b0, '0);
      collect(64, 200);
      tests_run++;
      if (q_data.size() != 64) begin
         tests_failed++; $display("FAIL sat_count: got %0d outputs expected 64", q_data.size());
      end
      for (int k = 0; k < q_data.size(); k++) begin
         tests_run++;
         if (q_data[k] !== exp_r[ZZ[k]]) begin
            tests_failed++;
            $display("FAIL sat_out[%0d]: got %0d expected %0d", k, $signed(q_data[k]), $signed(exp_r[ZZ[k]]));
         end
      end
   endtask

   // Table is all 16'hFFFF here, so each coefficient below 128 quantises to itself.
   task automatic test_back_to_back();
      int acc_cnt = 0;
      logic acc;
      out_ready = 1'b0;
      for (int c = 0; c < 200; c++) begin
         in_valid = 1'b1;
         in_coef  = 15'(acc_cnt);
         acc      = in_ready;
         @(posedge clk);
         if (acc) acc_cnt++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests_run++;
      if (acc_cnt != 128) begin
         tests_failed++; $display("FAIL bp_accepts: got %0d expected 128", acc_cnt);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++; $display("FAIL bp_in_ready: got %b expected 0", in_ready);
      end
      collect(128, 400);
      tests_run++;
      if (q_data.size() != 128) begin
         tests_failed++; $display("FAIL bp_count: got %0d outputs expected 128", q_data.size());
      end
      for (int k = 0; k < q_data.size(); k++) begin
         tests_run++;
         if (q_data[k] !== 12'((k / 64) * 64 + int'(ZZ[k % 64])) || q_zz[k] !== 6'(k % 64)
             || q_last[k] !== (k % 64 == 63)) begin
            tests_failed++;
            $display("FAIL bp_out[%0d]: got data %0d zz %0d last %b, expected %0d %0d %b", k,
                     q_data[k], q_zz[k], q_last[k], (k / 64) * 64 + int'(ZZ[k % 64]), k % 64, (k % 64 == 63));
         end
      end
      tests_run++;
      if (last_cyc - first_cyc != 127) begin
         tests_failed++; $display("FAIL bp_no_bubble: got span %0d cycles expected 127", last_cyc - first_cyc);
      end
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_drained: got in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_table_collision();
      apply_reset();
      for (int i = 0; i < 64; i++) stim[i] = '0;
      stim[0] = 15'd160;
      stim[1] = 15'd160;
      drive(64, 1'b1, 16'd8192);
      collect(64, 200);
      tests_run++;
      if (q_data.size() != 64 || q_data[0] !== 12'd10 || q_data[1] !== 12'd10) begin
         tests_failed++;
         $display("FAIL collision_old: got count %0d out0 %0d out1 %0d, expected 64 10 10",
                  q_data.size(), q_data[0], q_data[1]);
      end
      drive(64, 1'b0, '0);
      collect(64, 200);
      tests_run++;
      if (q_data.size() != 64 || q_data[0] !== 12'd20 || q_data[1] !== 12'd10) begin
         tests_failed++;
         $display("FAIL collision_new: got count %0d out0 %0d out1 %0d, expected 64 20 10",
                  q_data.size(), q_data[0], q_data[1]);
      end
   endtask

   task automatic test_reset_recovery();
      int seen = 0;
      for (int i = 0; i < 64; i++) stim[i] = 15'd16;
      drive(64, 1'b0, '0);
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++; $display("FAIL mid_drain_valid: got %b expected 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({out_valid, out_data, out_zz, out_last} !== '0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL drain_reset: got valid %b data %0d zz %0d last %b in_ready %b, expected 0 0 0 0 1",
                  out_valid, out_data, out_zz, out_last, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL drain_discard: got out_valid %b expected 0", out_valid);
      end
      out_ready = 1'b0;

      for (int i = 0; i < 64; i++) begin stim[i] = '0; exp_r[i] = '0; end
      stim[0]  = 15'd1000;   exp_r[0]  = 12'd63;
      stim[63] = -15'sd1000; exp_r[63] = -12'sd62;
      drive(30, 1'b0, '0);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL block_reset: got in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      tests_run++;
      if (seen != 0) begin
         tests_failed++; $display("FAIL partial_discard: got %0d outputs expected 0", seen);
      end
      drive(64, 1'b0, '0);
      collect(64, 200);
      tests_run++;
      if (q_data.size() != 64) begin
         tests_failed++; $display("FAIL recover_count: got %0d outputs expected 64", q_data.size());
      end
      for (int k = 0; k < q_data.size(); k++) begin
         tests_run++;
         if (q_data[k] !== exp_r[ZZ[k]] || q_last[k] !== (k == 63)) begin
            tests_failed++;
            $display("FAIL recover_out[%0d]: got data %0d last %b, expected %0d %b",
                     k, $signed(q_data[k]), q_last[k], $signed(exp_r[ZZ[k]]), (k == 63));
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_quant();
      test_zigzag_order();
      test_saturation();
      test_back_to_back();
      test_table_collision();
      test_reset_recovery();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
